mmio_uart_tx: RTL

//   Memory-mapped responder for the CPU data bus: answers CPU re/we cycles in the I/O window
//   (addr[15:13] != 0) and implements a buffered 8N1 UART transmitter.
//   CPU writes bytes into a TX FIFO, a serializer drives txd, and status/baud/control read back on rdata[9:0].

---
 rtl/mmio_uart_tx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Bus-mapped 8N1 UART transmitter: a four-register window feeds a small TX FIFO
// that drains through a baud-timed serializer onto txd.
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'hC000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [9:0]  DIV_RESET  = 10'd27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [9:0]  rdata,
  output logic        txd,
  output logic        tx_busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic       sel, wr, push_req, ctrl_wr, flush, ovf_clr;
  logic       full, pop, push_ok, push_drop;
  logic [1:0] off;
  logic [2:0] wr_ptr, rd_ptr, count;
  logic       ovf, en;
  logic [9:0] divisor;
  logic [7:0] mem [8];
  state_t     state;
  logic [9:0] bcnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic       unused_wdata;

  assign unused_wdata = ^wdata[15:10];

  assign sel      = (addr[15:2] == BASE_ADDR[15:2]);
  assign off      = addr[1:0];
  assign wr       = we & sel;
  assign push_req = wr & (off == 2'd0);
  assign ctrl_wr  = wr & (off == 2'd3);
  assign flush    = ctrl_wr & wdata[1];
  assign ovf_clr  = ctrl_wr & wdata[2];

  assign full      = (count == 3'(FIFO_DEPTH));
  assign pop       = (state == IDLE) & en & (count != 3'd0);
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push_req & ~flush & (~full | pop);
  assign push_drop = push_req & ~flush & full & ~pop;

  function automatic logic [2:0] nxt(input logic [2:0] p);
    return (p == 3'(FIFO_DEPTH - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= wdata[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      en      <= 1'b1;
      divisor <= DIV_RESET;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= nxt(wr_ptr);
        if (pop)     rd_ptr <= nxt(rd_ptr);
        count <= count + {2'b0, push_ok} - {2'b0, pop};
      end
      if (ovf_clr)   ovf <= 1'b0;
      if (push_drop) ovf <= 1'b1;
      if (ctrl_wr)   en  <= wdata[0];
      if (wr && off == 2'd2) divisor <= wdata[9:0];
    end
  end

  // txd is registered from the next-state decision so it changes on the same edge as state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      txd   <= 1'b1;
      bcnt  <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          shift <= mem[rd_ptr];
          bcnt  <= divisor;
          state <= START;
          txd   <= 1'b0;
        end
        START: if (bcnt == 10'd0) begin
          bcnt  <= divisor;
          idx   <= '0;
          state <= DATA;
          txd   <= shift[0];
        end else bcnt <= bcnt - 10'd1;
        DATA: if (bcnt == 10'd0) begin
          shift <= shift >> 1;
          bcnt  <= divisor;
          if (idx == 3'd7) begin
            state <= STOP;
            txd   <= 1'b1;
          end else begin
            idx <= idx + 3'd1;
            txd <= shift[1];
          end
        end else bcnt <= bcnt - 10'd1;
        STOP: if (bcnt == 10'd0) state <= IDLE;
              else bcnt <= bcnt - 10'd1;
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_busy = (state != IDLE) | (count != 3'd0);

  always_comb begin
    rdata = '0;
    if (re & sel)
      case (off)
        2'd1:    rdata = {4'b0, ovf, state != IDLE, full, count};
        2'd2:    rdata = divisor;
        2'd3:    rdata = {9'b0, en};
        default: rdata = '0;
      endcase
  end

endmodule
